// File: rtl/square_game_sequencer.sv
// Game-level sequencer: debounced start/pause button, frame-synchronised position commit,
// lives/frame budget bookkeeping and the IDLE/PLAY/PAUSE/OVER state machine.
module square_game_sequencer #(
    parameter int unsigned START_X         = 300,
    parameter int unsigned START_Y         = 220,
    parameter int unsigned ROUND_FRAMES    = 1800,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnC,
    input  logic        refresh_tick,
    input  logic [19:0] position_next,
    input  logic        hit,
    output logic [19:0] position,
    output logic        status,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [10:0] frames_left,
    output logic        win
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0]      START_POS = {10'(START_Y), 10'(START_X)};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    logic [1:0]       btn_sync;
    logic             btn_acc;
    logic             btn_acc_d;
    logic [CNT_W-1:0] db_cnt;
    logic [2:0]       tick_sync;
    logic             press;
    logic             frame;

    state_t      state_q, state_n;
    logic [19:0] pos_q, pos_n;
    logic [1:0]  lives_q, lives_n;
    logic [10:0] frames_q, frames_n;
    logic        win_q, win_n;
    logic        status_q;

    // Button synchroniser + debounce, frame strobe synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync  <= '0;
            btn_acc   <= 1'b0;
            btn_acc_d <= 1'b0;
            db_cnt    <= '0;
            tick_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[0], btnC};
            btn_acc_d <= btn_acc;
            if (btn_sync[1] == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                btn_acc <= btn_sync[1];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
            tick_sync <= {tick_sync[1:0], refresh_tick};
        end
    end

    assign press = btn_acc & ~btn_acc_d;
    assign frame = tick_sync[1] & ~tick_sync[2];

    // State and game registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pos_q    <= START_POS;
            lives_q  <= 2'd0;
            frames_q <= 11'd0;
            win_q    <= 1'b0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            pos_q    <= pos_n;
            lives_q  <= lives_n;
            frames_q <= frames_n;
            win_q    <= win_n;
            status_q <= (state_n == PLAY);
        end
    end

    // Next-state: a frame is fully applied before a coincident press; ending the game beats pausing
    always_comb begin
        state_n  = state_q;
        pos_n    = pos_q;
        lives_n  = lives_q;
        frames_n = frames_q;
        win_n    = win_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_n  = PLAY;
                    pos_n    = START_POS;
                    lives_n  = 2'(LIVES);
                    frames_n = 11'(ROUND_FRAMES);
                    win_n    = 1'b0;
                end
            end
            PLAY: begin
                if (frame) begin
                    if (hit) begin
                        lives_n = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        pos_n   = START_POS;
                    end else begin
                        pos_n = position_next;
                    end
                    frames_n = (frames_q != 11'd0) ? frames_q - 11'd1 : 11'd0;
                end
                if (frame && hit && (lives_n == 2'd0)) begin
                    state_n = OVER;
                    win_n   = 1'b0;
                end else if (frame && (frames_n == 11'd0)) begin
                    state_n = OVER;
                    win_n   = 1'b1;
                end else if (press) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (press) state_n = PLAY;
            end
            OVER: begin
                if (press) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign position    = pos_q;
    assign status      = status_q;
    assign state       = state_q;
    assign lives       = lives_q;
    assign frames_left = frames_q;
    assign win         = win_q;

endmodule

// File: tb/tb_square_game_sequencer.sv
// Self-checking bench for square_game_sequencer with a game-rule reference model.
module tb_square_game_sequencer;

    localparam int D  = 4;
    localparam int RF = 5;
    localparam int LV = 2;
    localparam logic [19:0] START_POS = {10'd220, 10'd300};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btnC = 1'b0;
    logic        refresh_tick = 1'b0;
    logic [19:0] position_next = '0;
    logic        hit = 1'b0;
    logic [19:0] position;
    logic        status;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [10:0] frames_left;
    logic        win;

    always #5 clk = ~clk;

    square_game_sequencer #(
        .START_X(300), .START_Y(220), .ROUND_FRAMES(RF), .LIVES(LV), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .btnC(btnC), .refresh_tick(refresh_tick),
        .position_next(position_next), .hit(hit), .position(position), .status(status),
        .state(state), .lives(lives), .frames_left(frames_left), .win(win)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: game rules applied per accepted press / frame event
    int          m_state = 0;
    int          m_lives = 0;
    int          m_frames = 0;
    logic [19:0] m_pos = START_POS;
    logic        m_win = 1'b0;

    wire [36:0] dut_vec = {state, status, position, lives, frames_left, win};

    function automatic logic [36:0] model_vec();
        return {2'(m_state), (m_state == 1), m_pos, 2'(m_lives), 11'(m_frames), m_win};
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_frames = 0; m_pos = START_POS; m_win = 1'b0;
    endtask

    task automatic model_press();
        case (m_state)
            0: begin m_state = 1; m_pos = START_POS; m_lives = LV; m_frames = RF; m_win = 1'b0; end
            1: m_state = 2;
            2: m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    task automatic model_frame(input logic h, input logic [19:0] pn);
        if (m_state != 1) return;
        if (h) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_pos = START_POS;
        end else begin
            m_pos = pn;
        end
        m_frames = (m_frames > 0) ? m_frames - 1 : 0;
        if (h && m_lives == 0) begin m_state = 3; m_win = 1'b0; end
        else if (m_frames == 0) begin m_state = 3; m_win = 1'b1; end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_press();
        btnC = 1'b1;
        tick(D + 6);
        btnC = 1'b0;
        tick(D + 6);
        model_press();
    endtask

    task automatic do_frame(input logic h, input logic [19:0] pn);
        position_next = pn;
        hit = h;
        refresh_tick = 1'b1;
        tick(5);
        refresh_tick = 1'b0;
        tick(3);
        hit = 1'b0;
        model_frame(h, pn);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        nvec++;
        if (dut_vec !== {2'd0, 1'b0, START_POS, 2'd0, 11'd0, 1'b0}) begin
            nerr++; $display("FAIL reset_values: got %h expected %h", dut_vec, {2'd0, 1'b0, START_POS, 2'd0, 11'd0, 1'b0});
        end
        reset = 1'b1;
        model_reset();
        tick(2);
    endtask

    task automatic test_start();
        do_press();
        nvec++;
        if (dut_vec !== {2'd1, 1'b1, START_POS, 2'd2, 11'd5, 1'b0}) begin
            nerr++; $display("FAIL start_game: got %h expected %h", dut_vec, {2'd1, 1'b1, START_POS, 2'd2, 11'd5, 1'b0});
        end
    endtask

    task automatic test_frame_latency();
        logic [19:0] pn;
        pn = {10'd219, 10'd299};
        position_next = pn;
        hit = 1'b0;
        refresh_tick = 1'b1;
        tick(2);
        nvec++;
        if (position !== START_POS) begin
            nerr++; $display("FAIL latency_early: got %h expected %h", position, START_POS);
        end
        tick(1);
        nvec++;
        if ({position, frames_left} !== {pn, 11'd4}) begin
            nerr++; $display("FAIL latency_3clk: got %h expected %h", {position, frames_left}, {pn, 11'd4});
        end
        refresh_tick = 1'b0;
        tick(3);
        model_frame(1'b0, pn);
        nvec++;
        if (dut_vec !== model_vec()) begin
            nerr++; $display("FAIL frame_move: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_hits();
        do_frame(1'b1, 20'($urandom));
        nvec++;
        if ({lives, position, state} !== {2'd1, START_POS, 2'd1} || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL first_hit: got %h expected %h", dut_vec, model_vec());
        end
        do_frame(1'b1, 20'($urandom));
        nvec++;
        if ({state, win, status} !== {2'd3, 1'b0, 1'b0} || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL last_hit_over: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_timeout();
        do_press();
        nvec++;
        if (state !== 2'd0 || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL over_to_idle: got %h expected %h", dut_vec, model_vec());
        end
        do_press();
        for (int i = 0; i < RF; i++) begin
            do_frame(1'b0, 20'($urandom));
            nvec++;
            if (dut_vec !== model_vec()) begin
                nerr++; $display("FAIL timeout_frame%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        nvec++;
        if ({state, win, frames_left, status} !== {2'd3, 1'b1, 11'd0, 1'b0}) begin
            nerr++; $display("FAIL timeout_win: got %h expected %h", {state, win, frames_left, status}, {2'd3, 1'b1, 11'd0, 1'b0});
        end
        do_press();
        do_press();
        nvec++;
        if ({state, lives, frames_left} !== {2'd1, 2'd2, 11'd5}) begin
            nerr++; $display("FAIL fresh_round: got %h expected %h", {state, lives, frames_left}, {2'd1, 2'd2, 11'd5});
        end
    endtask

    task automatic test_pause();
        btnC = 1'b1;
        tick(2);
        btnC = 1'b0;
        tick(12);
        nvec++;
        if (dut_vec !== model_vec()) begin
            nerr++; $display("FAIL glitch_ignored: got %h expected %h", dut_vec, model_vec());
        end
        do_press();
        nvec++;
        if ({state, status} !== {2'd2, 1'b0} || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL pause_enter: got %h expected %h", dut_vec, model_vec());
        end
        do_frame(1'b1, 20'($urandom));
        do_frame(1'b0, 20'($urandom));
        nvec++;
        if (dut_vec !== model_vec()) begin
            nerr++; $display("FAIL pause_frozen: got %h expected %h", dut_vec, model_vec());
        end
        do_press();
        nvec++;
        if ({state, status, lives, frames_left} !== {2'd1, 1'b1, 2'd2, 11'd5}) begin
            nerr++; $display("FAIL pause_resume: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    // Press pulse and frame pulse land on the same clock
    task automatic coincide(input logic h, input logic [19:0] pn);
        position_next = pn;
        hit = h;
        btnC = 1'b1;
        tick(D);
        refresh_tick = 1'b1;
        tick(5);
        refresh_tick = 1'b0;
        tick(3);
        btnC = 1'b0;
        hit = 1'b0;
        tick(D + 6);
        model_frame(h, pn);
        if (m_state == 1) m_state = 2;
    endtask

    task automatic test_press_with_frame();
        coincide(1'b0, 20'($urandom));
        nvec++;
        if (dut_vec !== model_vec()) begin
            nerr++; $display("FAIL press_frame_pause: got %h expected %h", dut_vec, model_vec());
        end
        do_press();
        do_frame(1'b1, 20'($urandom));
        coincide(1'b1, 20'($urandom));
        nvec++;
        if (state !== 2'd3 || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL press_frame_over: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 3) do_press();
            else do_frame(($urandom_range(0, 4) == 0), 20'($urandom));
            nvec++;
            if (dut_vec !== model_vec()) begin
                nerr++; $display("FAIL random_step%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4 && m_state != 1; i++) do_press();
        do_frame(1'b0, 20'($urandom) | 20'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        nvec++;
        if ({state, position, status, lives, frames_left, win} !== {2'd0, START_POS, 1'b0, 2'd0, 11'd0, 1'b0}) begin
            nerr++; $display("FAIL async_reset: got %h expected %h", dut_vec, {2'd0, 1'b0, START_POS, 2'd0, 11'd0, 1'b0});
        end
        tick(2);
        reset = 1'b1;
        model_reset();
        tick(2);
        do_press();
        nvec++;
        if ({state, lives, frames_left, position} !== {2'd1, 2'd2, 11'd5, START_POS} || dut_vec !== model_vec()) begin
            nerr++; $display("FAIL restart_after_reset: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_frame_latency();
        test_hits();
        test_timeout();
        test_pause();
        test_press_with_frame();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
